// File: rtl/kl_branch_pkg.sv
// Shared definitions for the delayed-branch resolve logic: condition codes,
// resolve FSM states, the pipeline entry record and the HALT head constant.
package kl_branch_pkg;

    localparam logic [2:0] COND_NV = 3'd0;
    localparam logic [2:0] COND_AL = 3'd1;
    localparam logic [2:0] COND_EQ = 3'd2;
    localparam logic [2:0] COND_NE = 3'd3;
    localparam logic [2:0] COND_LT = 3'd4;
    localparam logic [2:0] COND_LE = 3'd5;
    localparam logic [2:0] COND_GT = 3'd6;
    localparam logic [2:0] COND_GE = 3'd7;

    // HALT_immediately head (8'b001_00_111) placed in bits [15:8] of a word
    localparam logic [15:0] HALT_HEAD = 16'h2700;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        INJECT = 2'd1,
        DRAIN  = 2'd2
    } brs_state_t;

    typedef struct packed {
        logic        vld;
        logic [15:0] word;
        logic [2:0]  cond;
    } entry_t;

    localparam int ENTRY_W = $bits(entry_t);

endpackage

// File: rtl/cond_eval.sv
// Evaluates a 3-bit branch condition code against the N/V/Z flags.
module cond_eval
    import kl_branch_pkg::*;
(
    input  logic [2:0] cond,
    input  logic       N,
    input  logic       V,
    input  logic       Z,
    output logic       true
);

    logic lt;
    logic le;

    assign lt = N ^ V;
    assign le = lt | Z;

    // Decode the condition code into a single taken/not-taken bit
    always_comb begin
        true = 1'b0;
        case (cond)
            COND_NV: true = 1'b0;
            COND_AL: true = 1'b1;
            COND_EQ: true = Z;
            COND_NE: true = ~Z;
            COND_LT: true = lt;
            COND_LE: true = le;
            COND_GT: true = ~le;
            COND_GE: true = ~lt;
            default: true = 1'b0;
        endcase
    end

endmodule

// File: rtl/vDFF_en.sv
// Generic register with synchronous active-high clear and load enable.
module vDFF_en #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    // Clear wins over enable so a reset always lands even while stalled
    always_ff @(posedge clk) begin
        if (rst)
            q <= '0;
        else if (en)
            q <= d;
    end

endmodule

// File: rtl/branch_resolve_unit.sv
// Resolves delayed branches for two issue lanes: tracks entries through
// stages 2 and 3, evaluates conditions at stage 3 and, on a taken branch,
// flushes younger work and injects the branch word into the IR path.
module branch_resolve_unit
    import kl_branch_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        adv,
    input  logic [15:0] p0_db_in,
    input  logic [2:0]  p0_cond_in,
    input  logic        p0_vld_in,
    input  logic [15:0] p1_db_in,
    input  logic [2:0]  p1_cond_in,
    input  logic        p1_vld_in,
    input  logic        N,
    input  logic        V,
    input  logic        Z,
    output logic        p0_do_delayed_B,
    output logic        p1_do_delayed_B,
    output logic [15:0] inject_IR,
    output logic        flush_out,
    output logic        busy
);

    brs_state_t  state;
    logic [15:0] latched_word;
    logic        latched_lane;

    entry_t p0_e1, p0_e2, p1_e1, p1_e2;
    entry_t p0_e1_next, p0_e2_next, p1_e1_next, p1_e2_next;

    logic p0_true, p1_true;
    logic hit_p0, hit_p1, any_hit;
    logic commit;
    logic shift_in;

    cond_eval u_cond_p0 (
        .cond (p0_e2.cond),
        .N    (N),
        .V    (V),
        .Z    (Z),
        .true (p0_true)
    );

    cond_eval u_cond_p1 (
        .cond (p1_e2.cond),
        .N    (N),
        .V    (V),
        .Z    (Z),
        .true (p1_true)
    );

    // Invalid entries never hit; a hit only counts while running and advancing
    assign hit_p0   = p0_e2.vld & p0_true;
    assign hit_p1   = p1_e2.vld & p1_true;
    assign any_hit  = hit_p0 | hit_p1;
    assign commit   = (state == RUN) & adv & any_hit & ~rst;
    assign shift_in = (state == RUN) & ~any_hit;

    // Normal shifting only in RUN without a hit; a redirect empties both stages
    always_comb begin
        p0_e1_next = '0;
        p1_e1_next = '0;
        p0_e2_next = '0;
        p1_e2_next = '0;
        if (shift_in) begin
            p0_e1_next = '{vld: p0_vld_in, word: p0_db_in, cond: p0_cond_in};
            p1_e1_next = '{vld: p1_vld_in, word: p1_db_in, cond: p1_cond_in};
            p0_e2_next = p0_e1;
            p1_e2_next = p1_e1;
        end
    end

    vDFF_en #(.WIDTH(ENTRY_W)) u_p0_e1 (.clk(clk), .rst(rst), .en(adv), .d(p0_e1_next), .q(p0_e1));
    vDFF_en #(.WIDTH(ENTRY_W)) u_p0_e2 (.clk(clk), .rst(rst), .en(adv), .d(p0_e2_next), .q(p0_e2));
    vDFF_en #(.WIDTH(ENTRY_W)) u_p1_e1 (.clk(clk), .rst(rst), .en(adv), .d(p1_e1_next), .q(p1_e1));
    vDFF_en #(.WIDTH(ENTRY_W)) u_p1_e2 (.clk(clk), .rst(rst), .en(adv), .d(p1_e2_next), .q(p1_e2));

    // Redirect FSM: latch the older winning lane, then inject and drain
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= RUN;
            latched_word <= '0;
            latched_lane <= 1'b0;
        end else if (adv) begin
            case (state)
                RUN: begin
                    if (any_hit) begin
                        state        <= INJECT;
                        latched_word <= hit_p0 ? p0_e2.word : p1_e2.word;
                        latched_lane <= ~hit_p0;
                    end
                end
                INJECT:  state <= DRAIN;
                DRAIN:   state <= RUN;
                default: state <= RUN;
            endcase
        end
    end

    assign inject_IR       = (state == INJECT) ? latched_word : 16'h0000;
    assign p0_do_delayed_B = (state == INJECT) & ~latched_lane;
    assign p1_do_delayed_B = (state == INJECT) &  latched_lane;
    assign flush_out       = (state == INJECT) | commit;
    assign busy            = (state != RUN);

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed bench for branch_resolve_unit: a table of per-cycle stimulus
// rows with hand-computed outputs, plus reset and long-stall sequences.
module tb_branch_resolve_unit;
    import kl_branch_pkg::*;

    typedef struct {
        logic        rst;
        logic        adv;
        logic        p0v;
        logic [2:0]  p0c;
        logic [15:0] p0w;
        logic        p1v;
        logic [2:0]  p1c;
        logic [15:0] p1w;
        logic [2:0]  nvz;
        logic        e_flush;
        logic [15:0] e_ir;
        logic        e_d0;
        logic        e_d1;
        logic        e_busy;
    } vec_t;

    logic        clk;
    logic        rst;
    logic        adv;
    logic [15:0] p0_db_in;
    logic [2:0]  p0_cond_in;
    logic        p0_vld_in;
    logic [15:0] p1_db_in;
    logic [2:0]  p1_cond_in;
    logic        p1_vld_in;
    logic        N, V, Z;
    logic        p0_do_delayed_B;
    logic        p1_do_delayed_B;
    logic [15:0] inject_IR;
    logic        flush_out;
    logic        busy;

    int total;
    int bad;
    vec_t vecs[$];
    logic [15:0] halt_word;

    branch_resolve_unit dut (
        .clk             (clk),
        .rst             (rst),
        .adv             (adv),
        .p0_db_in        (p0_db_in),
        .p0_cond_in      (p0_cond_in),
        .p0_vld_in       (p0_vld_in),
        .p1_db_in        (p1_db_in),
        .p1_cond_in      (p1_cond_in),
        .p1_vld_in       (p1_vld_in),
        .N               (N),
        .V               (V),
        .Z               (Z),
        .p0_do_delayed_B (p0_do_delayed_B),
        .p1_do_delayed_B (p1_do_delayed_B),
        .inject_IR       (inject_IR),
        .flush_out       (flush_out),
        .busy            (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(input logic a,
                                input logic p0v, input logic [2:0] p0c, input logic [15:0] p0w,
                                input logic p1v, input logic [2:0] p1c, input logic [15:0] p1w,
                                input logic [2:0] nvz,
                                input logic ef, input logic [15:0] ei,
                                input logic e0, input logic e1, input logic eb);
        vec_t v;
        v.rst = 1'b0; v.adv = a;
        v.p0v = p0v; v.p0c = p0c; v.p0w = p0w;
        v.p1v = p1v; v.p1c = p1c; v.p1w = p1w;
        v.nvz = nvz;
        v.e_flush = ef; v.e_ir = ei; v.e_d0 = e0; v.e_d1 = e1; v.e_busy = eb;
        return v;
    endfunction

    function automatic vec_t idle(input logic a, input logic [2:0] nvz,
                                  input logic ef, input logic [15:0] ei,
                                  input logic e0, input logic e1, input logic eb);
        return mk(a, 1'b0, COND_NV, 16'h0000, 1'b0, COND_NV, 16'h0000, nvz, ef, ei, e0, e1, eb);
    endfunction

    // Inputs change on the falling edge and settle before outputs are sampled
    task automatic applyStimulus(input vec_t v);
        @(negedge clk);
        rst        = v.rst;
        adv        = v.adv;
        p0_vld_in  = v.p0v;
        p0_cond_in = v.p0c;
        p0_db_in   = v.p0w;
        p1_vld_in  = v.p1v;
        p1_cond_in = v.p1c;
        p1_db_in   = v.p1w;
        N          = v.nvz[2];
        V          = v.nvz[1];
        Z          = v.nvz[0];
        #1;
    endtask

    task automatic checkOutput(input string name, input int idx, input vec_t v);
        total++;
        if ({flush_out, inject_IR, p0_do_delayed_B, p1_do_delayed_B, busy} !==
            {v.e_flush, v.e_ir, v.e_d0, v.e_d1, v.e_busy}) begin
            bad++;
            $display("[TB] FAIL %s step %0d: got flush=%b ir=%h d0=%b d1=%b busy=%b, want flush=%b ir=%h d0=%b d1=%b busy=%b",
                     name, idx, flush_out, inject_IR, p0_do_delayed_B, p1_do_delayed_B, busy,
                     v.e_flush, v.e_ir, v.e_d0, v.e_d1, v.e_busy);
        end
    endtask

    task automatic step(input string name, input int idx, input vec_t v);
        applyStimulus(v);
        checkOutput(name, idx, v);
    endtask

    initial begin
        vec_t v;
        total     = 0;
        bad       = 0;
        halt_word = HALT_HEAD | 16'h0005;

        rst = 1'b1; adv = 1'b0;
        p0_vld_in = 1'b0; p0_cond_in = 3'd0; p0_db_in = 16'h0;
        p1_vld_in = 1'b0; p1_cond_in = 3'd0; p1_db_in = 16'h0;
        N = 1'b0; V = 1'b0; Z = 1'b0;
        repeat (2) @(posedge clk);

        // Reset state
        vecs.push_back(idle(1, 3'b000, 0, 16'h0000, 0, 0, 0));
        // p0 EQ 2011, Z=1 at stage 3: flush on commit, inject next, 2-cycle overhead
        vecs.push_back(mk(1, 1, COND_EQ, 16'h2011, 0, COND_NV, 16'h0, 3'b000, 0, 16'h0000, 0, 0, 0));
        vecs.push_back(idle(1, 3'b000, 0, 16'h0000, 0, 0, 0));
        vecs.push_back(idle(1, 3'b001, 1, 16'h0000, 0, 0, 0));
        vecs.push_back(idle(1, 3'b000, 1, 16'h2011, 1, 0, 1));
        vecs.push_back(idle(1, 3'b000, 0, 16'h0000, 0, 0, 1));
        vecs.push_back(idle(1, 3'b000, 0, 16'h0000, 0, 0, 0));
        // Both lanes AL: older p0 wins, p1 discarded
        vecs.push_back(mk(1, 1, COND_AL, 16'h2020, 1, COND_AL, 16'h2030, 3'b000, 0, 16'h0000, 0, 0, 0));
        vecs.push_back(idle(1, 3'b000, 0, 16'h0000, 0, 0, 0));
        vecs.push_back(idle(1, 3'b000, 1, 16'h0000, 0, 0, 0));
        vecs.push_back(idle(1, 3'b000, 1, 16'h2020, 1, 0, 1));
        vecs.push_back(idle(1, 3'b000, 0, 16'h0000, 0, 0, 1));
        vecs.push_back(idle(1, 3'b000, 0, 16'h0000, 0, 0, 0));
        // p0 EQ with Z=0 and p1 LT with N=V=1: neither hits
        vecs.push_back(mk(1, 1, COND_EQ, 16'h2012, 1, COND_LT, 16'h2040, 3'b000, 0, 16'h0000, 0, 0, 0));
        vecs.push_back(idle(1, 3'b000, 0, 16'h0000, 0, 0, 0));
        vecs.push_back(idle(1, 3'b110, 0, 16'h0000, 0, 0, 0));
        vecs.push_back(idle(1, 3'b000, 0, 16'h0000, 0, 0, 0));
        // p1 LE with N=V=0, Z=1: hit, inject on p1
        vecs.push_back(mk(1, 0, COND_NV, 16'h0, 1, COND_LE, 16'h2050, 3'b000, 0, 16'h0000, 0, 0, 0));
        vecs.push_back(idle(1, 3'b000, 0, 16'h0000, 0, 0, 0));
        vecs.push_back(idle(1, 3'b001, 1, 16'h0000, 0, 0, 0));
        vecs.push_back(idle(1, 3'b000, 1, 16'h2050, 0, 1, 1));
        vecs.push_back(idle(1, 3'b000, 0, 16'h0000, 0, 0, 1));
        vecs.push_back(idle(1, 3'b000, 0, 16'h0000, 0, 0, 0));
        // HALT word: p0 NV never injects, p1 AL injects it unchanged
        vecs.push_back(mk(1, 1, COND_NV, halt_word, 1, COND_AL, halt_word, 3'b000, 0, 16'h0000, 0, 0, 0));
        vecs.push_back(idle(1, 3'b000, 0, 16'h0000, 0, 0, 0));
        vecs.push_back(idle(1, 3'b000, 1, 16'h0000, 0, 0, 0));
        vecs.push_back(idle(1, 3'b000, 1, 16'h2705, 0, 1, 1));
        vecs.push_back(idle(1, 3'b000, 0, 16'h0000, 0, 0, 1));
        vecs.push_back(idle(1, 3'b000, 0, 16'h0000, 0, 0, 0));
        // Invalid entries with AL never hit
        vecs.push_back(mk(1, 0, COND_AL, 16'h2060, 0, COND_AL, 16'h2061, 3'b000, 0, 16'h0000, 0, 0, 0));
        vecs.push_back(idle(1, 3'b000, 0, 16'h0000, 0, 0, 0));
        vecs.push_back(idle(1, 3'b111, 0, 16'h0000, 0, 0, 0));
        // Younger entries in flight or arriving during redirect are dropped
        vecs.push_back(mk(1, 1, COND_AL, 16'h2070, 0, COND_NV, 16'h0, 3'b000, 0, 16'h0000, 0, 0, 0));
        vecs.push_back(mk(1, 1, COND_AL, 16'h2080, 0, COND_NV, 16'h0, 3'b000, 0, 16'h0000, 0, 0, 0));
        vecs.push_back(mk(1, 1, COND_AL, 16'h2090, 0, COND_NV, 16'h0, 3'b000, 1, 16'h0000, 0, 0, 0));
        vecs.push_back(mk(1, 1, COND_AL, 16'h20A0, 0, COND_NV, 16'h0, 3'b000, 1, 16'h2070, 1, 0, 1));
        vecs.push_back(mk(1, 1, COND_AL, 16'h20B1, 0, COND_NV, 16'h0, 3'b000, 0, 16'h0000, 0, 0, 1));
        vecs.push_back(idle(1, 3'b000, 0, 16'h0000, 0, 0, 0));
        vecs.push_back(idle(1, 3'b000, 0, 16'h0000, 0, 0, 0));
        vecs.push_back(idle(1, 3'b000, 0, 16'h0000, 0, 0, 0));
        // adv=0 in RUN: no load, no commit of a pending hit
        vecs.push_back(mk(1, 1, COND_AL, 16'h20B0, 0, COND_NV, 16'h0, 3'b000, 0, 16'h0000, 0, 0, 0));
        vecs.push_back(mk(0, 1, COND_AL, 16'h20C0, 0, COND_NV, 16'h0, 3'b000, 0, 16'h0000, 0, 0, 0));
        vecs.push_back(idle(1, 3'b000, 0, 16'h0000, 0, 0, 0));
        vecs.push_back(idle(0, 3'b000, 0, 16'h0000, 0, 0, 0));
        vecs.push_back(idle(1, 3'b000, 1, 16'h0000, 0, 0, 0));
        vecs.push_back(idle(1, 3'b000, 1, 16'h20B0, 1, 0, 1));
        vecs.push_back(idle(1, 3'b000, 0, 16'h0000, 0, 0, 1));
        vecs.push_back(idle(1, 3'b000, 0, 16'h0000, 0, 0, 0));

        foreach (vecs[i]) step("table", i, vecs[i]);

        // Reset mid-INJECT, with adv=1 and a valid input present during reset
        step("rst_inj", 0, mk(1, 1, COND_EQ, 16'h2011, 0, COND_NV, 16'h0, 3'b000, 0, 16'h0000, 0, 0, 0));
        step("rst_inj", 1, idle(1, 3'b000, 0, 16'h0000, 0, 0, 0));
        step("rst_inj", 2, idle(1, 3'b001, 1, 16'h0000, 0, 0, 0));
        step("rst_inj", 3, idle(0, 3'b000, 1, 16'h2011, 1, 0, 1));
        v = mk(1, 1, COND_AL, 16'h3333, 1, COND_AL, 16'h3334, 3'b000, 0, 16'h0, 0, 0, 0);
        v.rst = 1'b1;
        applyStimulus(v);
        step("rst_inj", 4, idle(0, 3'b000, 0, 16'h0000, 0, 0, 0));
        for (int k = 5; k < 8; k++) step("rst_inj", k, idle(1, 3'b000, 0, 16'h0000, 0, 0, 0));

        // Reset clears a pending stage-3 hit
        step("rst_pend", 0, mk(1, 0, COND_NV, 16'h0, 1, COND_AL, 16'h2222, 3'b000, 0, 16'h0000, 0, 0, 0));
        step("rst_pend", 1, idle(1, 3'b000, 0, 16'h0000, 0, 0, 0));
        step("rst_pend", 2, idle(0, 3'b000, 0, 16'h0000, 0, 0, 0));
        v = idle(0, 3'b000, 0, 16'h0, 0, 0, 0);
        v.rst = 1'b1;
        applyStimulus(v);
        step("rst_pend", 3, idle(1, 3'b000, 0, 16'h0000, 0, 0, 0));
        step("rst_pend", 4, idle(1, 3'b000, 0, 16'h0000, 0, 0, 0));

        // INJECT held for 5 stalled cycles, released one cycle after adv=1
        step("hold", 0, mk(1, 0, COND_NV, 16'h0, 1, COND_AL, 16'h2099, 3'b000, 0, 16'h0000, 0, 0, 0));
        step("hold", 1, idle(1, 3'b000, 0, 16'h0000, 0, 0, 0));
        step("hold", 2, idle(1, 3'b000, 1, 16'h0000, 0, 0, 0));
        for (int k = 3; k < 8; k++) step("hold", k, idle(0, 3'b000, 1, 16'h2099, 0, 1, 1));
        step("hold", 8, idle(1, 3'b000, 1, 16'h2099, 0, 1, 1));
        step("hold", 9, idle(1, 3'b000, 0, 16'h0000, 0, 0, 1));
        step("hold", 10, idle(1, 3'b000, 0, 16'h0000, 0, 0, 0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/branch_resolve_unit.md
BRANCH_RESOLVE_UNIT -- requirements
Module: branch_resolve_unit

Interface
REQ-001 SHALL have ports: clk input 1 (clock); rst input 1 (reset, synchronous, active-high).
REQ-002 SHALL have adv input 1: pipeline advance enable, same signal as fetch_next.
REQ-003 SHALL have p0_db_in input 16: lane-0 delayed branch word from BGU. Bits [15:8] are the head; bits [7:0] are the absolute destination.
REQ-004 SHALL have p0_cond_in input 3 (lane-0 delayed condition) and p0_vld_in input 1 (lane-0 entry valid).
REQ-005 SHALL have p1_db_in input 16, p1_cond_in input 3 and p1_vld_in input 1, with the same meanings for lane 1.
REQ-006 SHALL have N, V, Z inputs, 1 bit each: condition flags valid at stage 3.
REQ-007 SHALL have p0_do_delayed_B and p1_do_delayed_B outputs, 1 bit each: the injected word occupies that lane's IR and is decoded as absolute-destination format.
REQ-008 SHALL have inject_IR output 16: the word to inject into the IR path.
REQ-009 SHALL have flush_out output 1 (kill younger S1/S2 instructions) and busy output 1 (state not RUN).

Function
REQ-010 SHALL use condition codes NV=0, AL=1, EQ=2, NE=3, LT=4, LE=5, GT=6, GE=7.
REQ-011 SHALL evaluate conditions as: EQ=Z; NE=~Z; LT=N^V; LE=(N^V)|Z; GT=~LE; GE=~LT; AL=1; NV=0.
REQ-012 SHALL keep a two-stage entry pipeline per lane: E1 (stage 2) and E2 (stage 3). Each entry holds {vld, word[15:0], cond[2:0]}.
REQ-013 On adv=1 in RUN, SHALL load E1<=inputs and E2<=E1.
REQ-014 On adv=0, SHALL hold all entries and state, and SHALL NOT commit any evaluation.
REQ-015 SHALL compute hit_p0 = E2.p0.vld & cond_true(E2.p0.cond), and hit_p1 the same way for lane 1. A hit commits only when adv=1.
REQ-016 Lane priority: p0 is older than p1. If both lanes hit, p0 SHALL win and p1 SHALL be discarded.
REQ-017 FSM states SHALL be RUN, INJECT and DRAIN.
REQ-018 RUN->INJECT on a committed hit. In the same cycle: latch the winning word and lane, clear E1 of both lanes, assert flush_out.
REQ-019 In INJECT: inject_IR SHALL equal the latched word; the winning lane's do_delayed_B SHALL be 1 and the other 0; flush_out SHALL be 1; new inputs SHALL be dropped (E1 not loaded).
REQ-020 INJECT->DRAIN when adv=1 (word consumed). INJECT SHALL hold indefinitely while adv=0.
REQ-021 In DRAIN: outputs SHALL be idle, E1 and E2 SHALL be cleared, and the FSM SHALL return to RUN after one adv=1 cycle. Total redirect overhead is 2 advance cycles.
REQ-022 A head of 8'b001_00_111 (HALT_immediately) SHALL be treated as an ordinary word; no special decode is done here.
REQ-023 When idle, inject_IR SHALL be 16'h0000 and both do_delayed_B outputs SHALL be 0.
REQ-024 A hit on an entry with vld=0 SHALL be impossible. Invalid entries are never evaluated.

Reset
REQ-025 On rst=1: state=RUN; all entry vld bits=0; latched word=0; all outputs=0. This SHALL apply in any state, including mid-INJECT.
REQ-026 rst SHALL take priority over adv.

Structure
REQ-027 Condition-code constants and the FSM state enum SHALL reside in shared package kl_branch_pkg, together with the 16-bit HALT head constant.
REQ-028 The flag evaluation SHALL be a sub-module cond_eval (inputs cond, N, V, Z; output true), instantiated once per lane.
REQ-029 Entry registers SHALL use the codebase's vDFF_en with enable adv.

Verification
REQ-030 Reset check: p0 cond=EQ, Z=1, reach E2, rst mid-INJECT -> all outputs 0 next cycle; state RUN.
REQ-031 p0 word 16'h2011, cond EQ, adv=1 continuous, Z=1 at E2 -> flush_out=1 at commit; next cycle inject_IR=16'h2011 and p0_do_delayed_B=1; overhead is 2 cycles.
REQ-032 Both lanes cond=AL, words 16'h2020 and 16'h2030 -> only 16'h2020 injected on p0; p1_do_delayed_B never 1.
REQ-033 p1 cond=LT with N=1, V=1 -> no hit, no flush. Then cond=LE with N=0, V=0, Z=1 -> hit, inject on p1.
REQ-034 Hold adv=0 for 5 cycles during INJECT -> inject_IR and do_delayed_B stable; released one cycle after adv=1.
REQ-035 HALT word 16'h2705 with cond AL -> inject_IR=16'h2705 on the winning lane; cond NV entry with the same word never injects.
